// File: rtl/str_gen_pkg.sv
// Shared definitions for the framed string generator.
// Holds the FSM state encoding, frame mode codes, ASCII constants,
// LFSR tap selection and the payload byte formatting helpers.
package str_gen_pkg;

  localparam int unsigned CNT_W = 4;  // holds byte counts up to 8
  localparam int unsigned PAY_W = 5;  // LFSR bits consumed per payload byte

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_CAP  = 3'd2,
    ST_NUM  = 3'd3,
    ST_EOF  = 3'd4
  } state_e;

  localparam logic [2:0] MODE_OK       = 3'd0;
  localparam logic [2:0] MODE_SHORTCAP = 3'd1;
  localparam logic [2:0] MODE_LONGNUM  = 3'd2;
  localparam logic [2:0] MODE_LOWER    = 3'd3;
  localparam logic [2:0] MODE_TRUNC    = 3'd4;
  localparam logic [2:0] MODE_BADSTART = 3'd5;

  localparam logic [7:0] ASCII_NUL  = 8'h00;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_CASE = 8'h20;

  // Fibonacci tap mask (bit n-1 set for tap n); unknown widths fall back
  // to the top two bits, which still cycles but is not maximal length.
  function automatic logic [63:0] lfsr_taps(input int unsigned w);
    logic [63:0] m;
    case (w)
      32'd8:   m = 64'h0000_0000_0000_00B8;
      32'd16:  m = 64'h0000_0000_0000_B400;
      32'd24:  m = 64'h0000_0000_00E1_0000;
      32'd32:  m = 64'h0000_0000_8020_0003;
      default: m = 64'h3 << (w - 32'd2);
    endcase
    return m;
  endfunction

  // Letter byte: pseudo-random value folded into A..Z, or A+idx when fixed.
  function automatic logic [7:0] fmt_letter(input logic fixed,
                                            input logic [PAY_W-1:0] rnd,
                                            input logic [CNT_W-1:0] idx);
    logic [PAY_W-1:0] v;
    v = (rnd >= 5'd26) ? rnd - 5'd26 : rnd;
    return fixed ? ASCII_A + 8'(idx) : ASCII_A + 8'(v);
  endfunction

  // Digit byte: low nibble folded into 0..9, or 0+idx when fixed.
  function automatic logic [7:0] fmt_digit(input logic fixed,
                                           input logic [3:0] rnd,
                                           input logic [CNT_W-1:0] idx);
    logic [3:0] v;
    v = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;
    return fixed ? ASCII_0 + 8'(idx) : ASCII_0 + 8'(v);
  endfunction

endpackage

// File: rtl/str_gen_lfsr.sv
// Seedable Fibonacci LFSR for the payload generator.
// Ports: clk, rst (sync active-low, resets state to 1), load_i/seed_i load
// the seed (a zero seed loads 1 so the register never locks up), step_i
// advances one position. cur_o/nxt_o expose the low payload bits of the
// current and next state so the caller can format a byte for either.
module str_gen_lfsr
  import str_gen_pkg::*;
#(
  parameter int unsigned LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              step_i,
  output logic [PAY_W-1:0]  cur_o,
  output logic [PAY_W-1:0]  nxt_o
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] next_c;

  // Shift left, feedback into bit 0.
  assign next_c = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
  assign cur_o  = lfsr_q[PAY_W-1:0];
  assign nxt_o  = next_c[PAY_W-1:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? LFSR_W'(1) : seed_i;
    end else if (step_i) begin
      lfsr_d = next_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= LFSR_W'(1);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/str_gen.sv
// Framed string generator: emits 0x00, capital letters, digits, 0x00 per
// accepted start, over a valid/ready byte stream. A latched mode can inject
// format errors (short caps, long/truncated digits, lowercase, bad start).
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   start           begin a frame (honoured only in IDLE)
//   mode, seed      frame type and LFSR seed, latched on accepted start
//   out_data/valid  byte stream towards the consumer, out_ready accepts
//   busy            frame in progress
//   done            one-cycle pulse after the final 0x00 transfers
module str_gen
  import str_gen_pkg::*;
#(
  parameter int unsigned CAP_LEN = 2,
  parameter int unsigned NUM_LEN = 3,
  parameter int unsigned LFSR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [LFSR_W-1:0] seed,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic             fixed_q, fixed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             xfer_c;
  logic             lfsr_load_c;
  logic             lfsr_step_c;
  logic [PAY_W-1:0] lfsr_cur_c;
  logic [PAY_W-1:0] lfsr_nxt_c;
  logic [CNT_W-1:0] cap_tgt_c;
  logic [CNT_W-1:0] num_tgt_c;
  logic [CNT_W-1:0] cap_last_c;
  logic [CNT_W-1:0] num_last_c;

  str_gen_lfsr #(
    .LFSR_W(LFSR_W)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsr_load_c),
    .seed_i (seed),
    .step_i (lfsr_step_c),
    .cur_o  (lfsr_cur_c),
    .nxt_o  (lfsr_nxt_c)
  );

  assign xfer_c     = out_valid_q && out_ready;
  assign cap_last_c = cap_tgt_c - CNT_W'(1);
  assign num_last_c = num_tgt_c - CNT_W'(1);

  // Per-mode field lengths; bad start reuses the empty-CAP path.
  always_comb begin
    cap_tgt_c = CNT_W'(CAP_LEN);
    num_tgt_c = CNT_W'(NUM_LEN);
    case (mode_q)
      MODE_SHORTCAP: cap_tgt_c = CNT_W'(CAP_LEN - 1);
      MODE_LONGNUM:  num_tgt_c = CNT_W'(NUM_LEN + 1);
      MODE_TRUNC:    num_tgt_c = CNT_W'(NUM_LEN - 1);
      MODE_BADSTART: cap_tgt_c = '0;
      default:       ;
    endcase
  end

  // Next state and next output byte. The byte for the following beat is
  // formatted at the transfer of the current one, so CAP/NUM advances use
  // the LFSR's next value while the first byte after SOF uses its current one.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    fixed_d     = fixed_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lfsr_load_c = 1'b0;
    lfsr_step_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode;
          fixed_d     = (seed == '0);
          lfsr_load_c = 1'b1;
          cnt_d       = '0;
          state_d     = ST_SOF;
          out_valid_d = 1'b1;
          out_data_d  = ASCII_NUL;
          busy_d      = 1'b1;
        end
      end

      ST_SOF: begin
        if (xfer_c) begin
          cnt_d = '0;
          if (cap_tgt_c == '0) begin
            if (num_tgt_c == '0) begin
              state_d    = ST_EOF;
              out_data_d = ASCII_NUL;
            end else begin
              state_d    = ST_NUM;
              out_data_d = fmt_digit(fixed_q, lfsr_cur_c[3:0], '0);
            end
          end else begin
            state_d    = ST_CAP;
            out_data_d = fmt_letter(fixed_q, lfsr_cur_c, '0);
            if (mode_q == MODE_LOWER) begin
              out_data_d = out_data_d | ASCII_CASE;
            end
          end
        end
      end

      ST_CAP: begin
        if (xfer_c) begin
          lfsr_step_c = 1'b1;
          if (cnt_q == cap_last_c) begin
            cnt_d = '0;
            if (num_tgt_c == '0) begin
              state_d    = ST_EOF;
              out_data_d = ASCII_NUL;
            end else begin
              state_d    = ST_NUM;
              out_data_d = fmt_digit(fixed_q, lfsr_nxt_c[3:0], '0);
            end
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            out_data_d = fmt_letter(fixed_q, lfsr_nxt_c, cnt_q + CNT_W'(1));
          end
        end
      end

      ST_NUM: begin
        if (xfer_c) begin
          lfsr_step_c = 1'b1;
          if (cnt_q == num_last_c) begin
            cnt_d      = '0;
            state_d    = ST_EOF;
            out_data_d = ASCII_NUL;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            out_data_d = fmt_digit(fixed_q, lfsr_nxt_c[3:0], cnt_q + CNT_W'(1));
          end
        end
      end

      ST_EOF: begin
        if (xfer_c) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_data_d  = ASCII_NUL;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_OK;
      fixed_q     <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= ASCII_NUL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      fixed_q     <= fixed_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
